prog_store: RTL
===============

# prog_store

Loadable program store that feeds the MCX core its 46-bit instruction lines. It accepts a byte stream over a valid/ready port and assembles 16 lines into an internal register array. It drives the core's line bus from a combinational read of the core's address. It holds the core in reset until a complete program has been loaded.

## Interface
Parameters:
- DEPTH, 16, number of program lines.
- ADDR_W, 4, line address width; DEPTH = 2**ADDR_W.
- LINE_W, 46, line width: PC[45:42] cond[41:40] inst[39:36] arg1[35:24] arg2[23:12] arg3[11:0].

Ports:
- clk  in  1  single clock, all state on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- ld_start  in  1  one-cycle pulse: begin (or restart) loading at line 0.
- ld_data  in  8  load byte.
- ld_valid  in  1  ld_data valid.
- ld_ready  out  1  store accepts a byte this cycle.
- addr  in  ADDR_W  core read address (next_inst).
- line  out  LINE_W  program line at addr.
- loading  out  1  state is LOAD.
- done  out  1  a full program is resident.
- err  out  1  sticky checksum error (0 when checksum compiled out).
- core_nrst  out  1  active-low reset to the MCX core.

## Operation
- States: IDLE, LOAD, DONE.
- Reset, with nrst low at an edge:
  - state=IDLE; all memory lines=0.
  - byte_cnt=0, line_cnt=0.
  - ld_ready=0, loading=0, done=0, err=0, core_nrst=0.
- IDLE: ld_start → LOAD with byte_cnt=0, line_cnt=0, err cleared.
- LOAD:
  - ld_ready=1.
  - A byte is accepted when ld_valid && ld_ready.
  - Bytes per line are sent MSB-first:
    - B0[5:0] → line[45:40]; B0[7:6] are ignored.
    - B1 → [39:32], B2 → [31:24], B3 → [23:16], B4 → [15:8], B5 → [7:0].
  - The assembly register holds B0..B4; the write uses the register plus the final byte.
  - On acceptance of the last byte of a line, mem[line_cnt] is written. Then byte_cnt=0 and line_cnt+1.
  - When line_cnt=DEPTH-1 is written → DONE.
- DONE:
  - done=1.
  - core_nrst goes 1 on the edge after entering DONE (registered).
- ld_start in LOAD or DONE:
  - → LOAD, restarting at line 0 and byte 0; the partial line is discarded.
  - done=0; core_nrst=0 on the following edge.
  - Lines already stored keep their old contents until overwritten.
- ld_start while a byte is accepted in the same cycle: ld_start wins and the byte is dropped.
- ld_valid in IDLE or DONE: ignored, since ld_ready=0.
- Read port: line = mem[addr], combinational in all states. The core is in reset during IDLE and LOAD.
- line_cnt wraps never: LOAD always exits at DEPTH-1.
- Reset mid-load: returns to IDLE with memory cleared and core_nrst=0.

## Timing
- Byte acceptance: 1 per cycle max; no bubble required between lines.
- Write latency: the last byte accepted at edge N makes mem visible on line after edge N.
- Full load, no stalls: 16×6 = 96 accepted cycles.
  - done=1 after the 96th accept edge.
  - core_nrst=1 one edge later.
- loading and done are registered state decodes; they are never both 1.
- ld_ready is combinational from state only, with no dependence on ld_valid.

## Configuration
- PROG_STORE_CSUM_EN defined:
  - Each line carries a 7th byte B6 = B0^B1^B2^B3^B4^B5 (all 8 bits of B0 included).
  - On acceptance of B6 with a match, the line is written as above.
  - On a mismatch:
    - no write;
    - err=1 (sticky until the next ld_start or reset);
    - byte_cnt=0;
    - line_cnt unchanged, so the sender retransmits the same line.
  - Full load takes 112 accepts.
- Undefined: 6 bytes per line, no checksum logic; err tied 0.

## Structure
- Shared package mcx_pkg holds:
  - LINE_W, ADDR_W, DEPTH;
  - the field offset constants (PC_MSB, COND_MSB, INST_MSB, ARG1_MSB, ARG2_MSB, ARG3_MSB);
  - the prog_store state enum.
- One sub-module: prog_line_asm.
  - Byte counter, assembly register, optional checksum accumulator.
  - Emits line_wr_en plus the assembled line.
- prog_store keeps the FSM, line counter, memory array, read mux and core_nrst.

## Test plan
- Reset, then addr sweep 0..15 → line=0 for every addr; core_nrst=0, ld_ready=0, done=0.
- ld_start, stream 96 bytes with line k = {k[3:0],2'b01,4'h1,12'h00A,12'h801,12'h000} and ld_valid held high:
  - done=1 after the 96th accept;
  - core_nrst=1 one cycle later;
  - addr=5 → 46'h1 5 1 00A 801 000 with PC field 4'h5.
- Random ld_valid gaps (≈50% duty) on the same stream → identical memory contents; ld_ready stays 1 throughout LOAD.
- Mid-load ld_start after 40 bytes, then a full new program → all 16 lines match the new program; done rises only after 96 further accepts.
- nrst low for one cycle in DONE → memory reads 0, core_nrst=0 that edge, state IDLE.
- With PROG_STORE_CSUM_EN, line 3 sent with bad B6 (correct^8'h01) then resent correctly:
  - err=1 from the bad B6 onward;
  - mem[3] is correct after the resend;
  - done after 16 good lines; err stays 1 until the next ld_start.

Source files
------------

// File: rtl/mcx_pkg.sv
// Shared MCX definitions: program line geometry, field offsets and the
// program store state encoding.
// Optional feature macro: PROG_STORE_CSUM_EN adds a per-line XOR checksum byte.
package mcx_pkg;

    localparam int LINE_W = 46;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    // Most significant bit of each field inside a program line
    localparam int PC_MSB   = 45;
    localparam int COND_MSB = 41;
    localparam int INST_MSB = 39;
    localparam int ARG1_MSB = 35;
    localparam int ARG2_MSB = 23;
    localparam int ARG3_MSB = 11;

`ifdef PROG_STORE_CSUM_EN
    localparam int BYTES_PER_LINE = 7;
`else
    localparam int BYTES_PER_LINE = 6;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ps_state_e;

endpackage

// File: rtl/prog_line_asm.sv
// Assembles MSB-first load bytes into one program line and pulses
// line_wr_en on the final byte of each line.
// Optional feature macro: PROG_STORE_CSUM_EN (7th byte = XOR of bytes 0..5).
module prog_line_asm #(
    parameter int LINE_W = mcx_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic              line_wr_en,
`ifdef PROG_STORE_CSUM_EN
    output logic              csum_err,
`endif
    output logic [LINE_W-1:0] line_data
);
    import mcx_pkg::*;

    // Bytes held before the final one; B0[7:6] fall off the top of the shifter
    localparam int         ASM_W = (BYTES_PER_LINE - 1) * 8 - 2;
    localparam logic [2:0] LAST  = 3'(BYTES_PER_LINE - 1);

    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic [ASM_W-1:0] asm_q, asm_d;
`ifdef PROG_STORE_CSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    // Next-state for the byte counter, shifter and checksum; write strobe on last byte
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        line_wr_en = 1'b0;
`ifdef PROG_STORE_CSUM_EN
        csum_d     = csum_q;
        csum_err   = 1'b0;
        line_data  = asm_q;
`else
        line_data  = {asm_q, byte_in};
`endif
        if (clear) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            if (byte_cnt_q == LAST) begin
                byte_cnt_d = '0;
`ifdef PROG_STORE_CSUM_EN
                if (csum_q == byte_in) line_wr_en = 1'b1;
                else                   csum_err   = 1'b1;
`else
                line_wr_en = 1'b1;
`endif
            end else begin
                byte_cnt_d = byte_cnt_q + 3'd1;
                asm_d      = {asm_q[ASM_W-9:0], byte_in};
`ifdef PROG_STORE_CSUM_EN
                csum_d     = (byte_cnt_q == 3'd0) ? byte_in : (csum_q ^ byte_in);
`endif
            end
        end
    end

    // Assembly state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so all of them update together.
        if (!nrst) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
`ifdef PROG_STORE_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
`ifdef PROG_STORE_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: rtl/prog_store.sv
// Loadable MCX program store: byte-stream loader, 16-line register array,
// combinational read port and core reset hold-off until a full program is in.
// Optional feature macro: PROG_STORE_CSUM_EN (per-line checksum, sticky err).
module prog_store #(
    parameter int DEPTH  = mcx_pkg::DEPTH,
    parameter int ADDR_W = mcx_pkg::ADDR_W,
    parameter int LINE_W = mcx_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ld_start,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] addr,
    output logic [LINE_W-1:0] line,
    output logic              loading,
    output logic              done,
    output logic              err,
    output logic              core_nrst
);
    import mcx_pkg::*;

    ps_state_e         state_q, state_d;
    logic [ADDR_W-1:0] line_cnt_q, line_cnt_d;
    logic              core_nrst_q, core_nrst_d;
    logic [LINE_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic              accept;
    logic              line_wr_en;
    logic [LINE_W-1:0] line_data;

    assign ld_ready  = (state_q == ST_LOAD);
    assign loading   = (state_q == ST_LOAD);
    assign done      = (state_q == ST_DONE);
    assign core_nrst = core_nrst_q;
    assign line      = mem_q[addr];

    // A restart in the same cycle as a valid byte drops that byte
    assign accept = ld_valid && ld_ready && !ld_start;

`ifdef PROG_STORE_CSUM_EN
    logic csum_err;
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    prog_line_asm #(.LINE_W(LINE_W)) u_asm (
        .clk        (clk),
        .nrst       (nrst),
        .clear      (ld_start),
        .accept     (accept),
        .byte_in    (ld_data),
        .line_wr_en (line_wr_en),
`ifdef PROG_STORE_CSUM_EN
        .csum_err   (csum_err),
`endif
        .line_data  (line_data)
    );

    // FSM, line counter, write enable and registered core reset release
    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        mem_we      = 1'b0;
`ifdef PROG_STORE_CSUM_EN
        err_d       = err_q;
`endif
        if (ld_start) begin
            state_d    = ST_LOAD;
            line_cnt_d = '0;
`ifdef PROG_STORE_CSUM_EN
            err_d      = 1'b0;
`endif
        end else if (state_q == ST_LOAD) begin
`ifdef PROG_STORE_CSUM_EN
            if (csum_err) err_d = 1'b1;
`endif
            if (line_wr_en) begin
                mem_we = 1'b1;
                if (line_cnt_q == ADDR_W'(DEPTH - 1)) state_d    = ST_DONE;
                else                                  line_cnt_d = line_cnt_q + ADDR_W'(1);
            end
        end
        // Core leaves reset one edge after DONE is reached and re-enters it on restart
        core_nrst_d = (state_q == ST_DONE) && !ld_start;
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            line_cnt_q  <= '0;
            core_nrst_q <= 1'b0;
`ifdef PROG_STORE_CSUM_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            core_nrst_q <= core_nrst_d;
`ifdef PROG_STORE_CSUM_EN
            err_q       <= err_d;
`endif
        end
    end

    // Program line array: cleared on reset, written once per completed line
    always_ff @(posedge clk) begin
        // NOTE: this array is deliberately reset; the core must read zeros before any load.
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[line_cnt_q] <= line_data;
        end
    end

endmodule
